// File: rtl/aes_pkcs7_padder.sv
// PKCS#7 padder for the AES-CBC plaintext stream: completes the last partial word
// with the pad byte and appends whole pad words until the count is a multiple of 4.
module aes_pkcs7_padder #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_bytes_i,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [31:0]      out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       pad_o
);

  localparam int CW = LEN_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  state_e          state_r;
  logic [LEN_W-1:0] len_r;
  logic [4:0]      pad_r;
  logic [CW-1:0]   n_in_r;
  logic [CW-1:0]   n_out_r;
  logic [CW-1:0]   in_cnt_r;
  logic [CW-1:0]   ld_cnt_r;
  logic [31:0]     out_data_r;
  logic            out_valid_r;
  logic            out_last_r;
  logic            busy_r;
  logic            done_r;

  logic [LEN_W:0]  len_ext_s;
  logic [LEN_W:0]  n_in_sum_s;
  logic [LEN_W:0]  n_out_sum_s;
  logic [4:0]      pad_calc_s;
  logic [CW-1:0]   n_in_calc_s;
  logic [CW-1:0]   n_out_calc_s;
  logic [CW-1:0]   one_s;
  logic            load_ok_s;
  logic            in_ready_s;
  logic            in_fire_s;
  logic            out_fire_s;
  logic            last_idx_s;
  logic            more_out_s;
  logic            last_in_s;
  logic [2:0]      kept_s;
  logic [7:0]      pad_byte_s;
  logic [31:0]     pad_word_s;
  logic [31:0]     masked_s;

  // Quantities derived from the requested length; sums carry one extra bit so max L cannot wrap
  always_comb begin
    len_ext_s    = {1'b0, len_bytes_i};
    pad_calc_s   = 5'd16 - {1'b0, len_bytes_i[3:0]};
    n_in_sum_s   = len_ext_s + {{(LEN_W-1){1'b0}}, 2'b11};
    n_out_sum_s  = len_ext_s + {{(LEN_W-4){1'b0}}, pad_calc_s};
    n_in_calc_s  = n_in_sum_s[LEN_W:2];
    n_out_calc_s = n_out_sum_s[LEN_W:2];
  end

  // Handshake qualifiers and counter comparisons
  always_comb begin
    one_s      = {{(CW-1){1'b0}}, 1'b1};
    load_ok_s  = ~out_valid_r | out_ready_i;
    in_ready_s = (state_r == ST_PASS) & load_ok_s;
    in_fire_s  = in_valid_i & in_ready_s;
    out_fire_s = out_valid_r & out_ready_i;
    last_idx_s = (ld_cnt_r == (n_out_r - one_s));
    more_out_s = (ld_cnt_r < n_out_r);
    last_in_s  = (in_cnt_r == (n_in_r - one_s));
    pad_byte_s = {3'b000, pad_r};
    pad_word_s = {4{pad_byte_s}};
  end

  // Only the final input word can be partial; lanes past L are overwritten by the pad byte
  always_comb begin
    masked_s = in_data_i;
    if (len_r[1:0] == 2'b00) begin
      kept_s = 3'd4;
    end else begin
      kept_s = {1'b0, len_r[1:0]};
    end
    for (int j = 0; j < 4; j++) begin
      if (last_in_s && (3'(j) >= kept_s)) begin
        masked_s[8*j +: 8] = pad_byte_s;
      end else begin
        masked_s[8*j +: 8] = in_data_i[8*j +: 8];
      end
    end
  end

  // Control FSM and the single output register stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_r     <= ST_IDLE;
      len_r       <= {LEN_W{1'b0}};
      pad_r       <= 5'd0;
      n_in_r      <= {CW{1'b0}};
      n_out_r     <= {CW{1'b0}};
      in_cnt_r    <= {CW{1'b0}};
      ld_cnt_r    <= {CW{1'b0}};
      out_data_r  <= 32'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (out_fire_s) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            len_r    <= len_bytes_i;
            pad_r    <= pad_calc_s;
            n_in_r   <= n_in_calc_s;
            n_out_r  <= n_out_calc_s;
            in_cnt_r <= {CW{1'b0}};
            ld_cnt_r <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= (n_in_calc_s == {CW{1'b0}}) ? ST_PAD : ST_PASS;
          end
        end
        ST_PASS: begin
          if (in_fire_s) begin
            out_data_r  <= masked_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_idx_s;
            ld_cnt_r    <= ld_cnt_r + one_s;
            in_cnt_r    <= in_cnt_r + one_s;
            if (last_in_s) begin
              state_r <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          // With nothing left to load, PAD just drains the final word and closes the message
          if (more_out_s && load_ok_s) begin
            out_data_r  <= pad_word_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_idx_s;
            ld_cnt_r    <= ld_cnt_r + one_s;
          end
          if (out_fire_s && out_last_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign out_last_o  = out_last_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign pad_o       = pad_r;

endmodule

// File: tb/tb_aes_pkcs7_padder.sv
// Directed bench for aes_pkcs7_padder: one task per scenario, inline expected-value checks.
module tb_aes_pkcs7_padder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] len_bytes_i = 16'd0;
  logic [31:0] in_data_i = 32'd0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  pad_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] wv [0:15];
  logic [31:0] got_d [$];
  logic        got_l [$];
  int          done_cnt, rdy_seen, stall_err, n_hs;
  bit          timed_out;
  logic        busy_at_done;

  aes_pkcs7_padder #(.LEN_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .len_bytes_i(len_bytes_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o),
    .done_o(done_o), .pad_o(pad_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives one message and records every output handshake; stops at done_o or after a clear
  task automatic run_msg(input logic [15:0] len, input int nw, input bit rr, input bit rv,
                         input int clr_at, input bit mid_start);
    int idx, cyc;
    bit fin, pst;
    logic [31:0] pd;
    logic pl;
    got_d.delete(); got_l.delete();
    done_cnt = 0; rdy_seen = 0; stall_err = 0; n_hs = 0; timed_out = 0; busy_at_done = 1'b1;
    idx = 0; cyc = 0; fin = 0; pst = 0; pd = 32'd0; pl = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; len_bytes_i = len; in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(posedge clk_i);
    while (!fin && cyc < 400) begin
      @(negedge clk_i);
      start_i = mid_start && (cyc == 3);
      if (mid_start) len_bytes_i = 16'd40;
      clear_i = (clr_at >= 0) && (n_hs == clr_at);
      in_valid_i = !clear_i && (idx < nw) && (!rv || $urandom_range(0, 1) == 1);
      in_data_i = in_valid_i ? wv[idx] : 32'hDEAD_BEEF;
      out_ready_i = !clear_i && (!rr || $urandom_range(0, 1) == 1);
      #1;
      if (pst && (!out_valid_o || out_data_o !== pd || out_last_o !== pl)) stall_err++;
      pst = out_valid_o && !out_ready_i;
      pd = out_data_o;
      pl = out_last_o;
      if (done_o) begin
        done_cnt++;
        busy_at_done = busy_o;
        fin = 1;
      end
      if (in_ready_o) rdy_seen++;
      if (in_valid_i && in_ready_o) idx++;
      if (out_valid_o && out_ready_i && !clear_i) begin
        got_d.push_back(out_data_o);
        got_l.push_back(out_last_o);
        n_hs++;
      end
      if (clear_i) fin = 1;
      cyc++;
      @(posedge clk_i);
    end
    if (!fin) timed_out = 1;
    @(negedge clk_i);
    start_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    checks++; if (out_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last_o); end
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy_o, done_o); end
    checks++; if (pad_o !== 5'd0) begin errors++; $display("FAIL reset_pad got=%0d exp=0", pad_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_l16();
    logic [31:0] e;
    int extra;
    wv[0] = 32'h03020100; wv[1] = 32'h07060504; wv[2] = 32'h0B0A0908; wv[3] = 32'h0F0E0D0C;
    run_msg(16'd16, 4, 0, 0, -1, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL l16_timeout got=1 exp=0"); end
    checks++; if (got_d.size() != 8) begin errors++; $display("FAIL l16_count got=%0d exp=8", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 8; k++) begin
      e = (k < 4) ? wv[k] : 32'h10101010;
      checks++; if (got_d[k] !== e) begin errors++; $display("FAIL l16_data[%0d] got=%h exp=%h", k, got_d[k], e); end
      checks++; if (got_l[k] !== (k == 7)) begin errors++; $display("FAIL l16_last[%0d] got=%b exp=%b", k, got_l[k], k == 7); end
    end
    checks++; if (pad_o !== 5'd16) begin errors++; $display("FAIL l16_pad got=%0d exp=16", pad_o); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL l16_busy_at_done got=%b exp=0", busy_at_done); end
    extra = 0;
    repeat (3) begin @(negedge clk_i); #1; if (done_o) extra++; end
    checks++; if (done_cnt + extra != 1) begin errors++; $display("FAIL l16_done_once got=%0d exp=1", done_cnt + extra); end
  endtask

  task automatic test_l5();
    logic [31:0] ex [0:3];
    ex[0] = 32'h44332211; ex[1] = 32'h0B0B0B55; ex[2] = 32'h0B0B0B0B; ex[3] = 32'h0B0B0B0B;
    wv[0] = 32'h44332211; wv[1] = 32'hAABBCC55;
    run_msg(16'd5, 2, 0, 0, -1, 0);
    checks++; if (got_d.size() != 4 || timed_out) begin errors++; $display("FAIL l5_count got=%0d exp=4", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++; if (got_d[k] !== ex[k]) begin errors++; $display("FAIL l5_data[%0d] got=%h exp=%h", k, got_d[k], ex[k]); end
      checks++; if (got_l[k] !== (k == 3)) begin errors++; $display("FAIL l5_last[%0d] got=%b exp=%b", k, got_l[k], k == 3); end
    end
    checks++; if (pad_o !== 5'd11) begin errors++; $display("FAIL l5_pad got=%0d exp=11", pad_o); end
  endtask

  task automatic test_l0();
    wv[0] = 32'h12345678;
    run_msg(16'd0, 1, 0, 0, -1, 0);
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL l0_in_ready got=%0d exp=0", rdy_seen); end
    checks++; if (got_d.size() != 4 || timed_out) begin errors++; $display("FAIL l0_count got=%0d exp=4", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++; if (got_d[k] !== 32'h10101010) begin errors++; $display("FAIL l0_data[%0d] got=%h exp=10101010", k, got_d[k]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL l0_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_l15();
    wv[0] = 32'h03020100; wv[1] = 32'h07060504; wv[2] = 32'h0B0A0908; wv[3] = 32'hFF0E0D0C;
    run_msg(16'd15, 4, 0, 0, -1, 0);
    checks++; if (got_d.size() != 4 || timed_out) begin errors++; $display("FAIL l15_count got=%0d exp=4", got_d.size()); end
    if (got_d.size() == 4) begin
      checks++; if (got_d[3] !== 32'h010E0D0C) begin errors++; $display("FAIL l15_last_word got=%h exp=010e0d0c", got_d[3]); end
      checks++; if (got_d[2] !== 32'h0B0A0908) begin errors++; $display("FAIL l15_word2 got=%h exp=0b0a0908", got_d[2]); end
      checks++; if ({got_l[0], got_l[1], got_l[2], got_l[3]} !== 4'b0001) begin
        errors++; $display("FAIL l15_last_flags got=%b%b%b%b exp=0001", got_l[0], got_l[1], got_l[2], got_l[3]);
      end
    end
    checks++; if (pad_o !== 5'd1) begin errors++; $display("FAIL l15_pad got=%0d exp=1", pad_o); end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] e;
    for (int k = 0; k < 8; k++) wv[k] = 32'hA0B0C000 + 32'(k * 17);
    run_msg(16'd32, 8, 1, 1, -1, 0);
    checks++; if (got_d.size() != 12 || timed_out) begin errors++; $display("FAIL l32_count got=%0d exp=12", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 12; k++) begin
      e = (k < 8) ? wv[k] : 32'h10101010;
      checks++; if (got_d[k] !== e) begin errors++; $display("FAIL l32_data[%0d] got=%h exp=%h", k, got_d[k], e); end
      checks++; if (got_l[k] !== (k == 11)) begin errors++; $display("FAIL l32_last[%0d] got=%b exp=%b", k, got_l[k], k == 11); end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL l32_stall_stable got=%0d exp=0", stall_err); end
  endtask

  task automatic test_clear();
    int extra;
    for (int k = 0; k < 5; k++) wv[k] = 32'h55000000 + 32'(k);
    run_msg(16'd20, 5, 0, 0, 2, 0);
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy_o); end
    extra = done_cnt;
    repeat (3) begin @(negedge clk_i); #1; if (done_o) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL clr_no_done got=%0d exp=0", extra); end
    wv[0] = 32'hCAFEF00D;
    run_msg(16'd4, 1, 0, 0, -1, 1);
    checks++; if (got_d.size() != 4 || timed_out) begin errors++; $display("FAIL l4_count got=%0d exp=4", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 4; k++) begin
      checks++; if (got_d[k] !== ((k == 0) ? 32'hCAFEF00D : 32'h0C0C0C0C)) begin
        errors++; $display("FAIL l4_data[%0d] got=%h exp=%h", k, got_d[k], (k == 0) ? 32'hCAFEF00D : 32'h0C0C0C0C);
      end
    end
    checks++; if (pad_o !== 5'd12) begin errors++; $display("FAIL l4_pad got=%0d exp=12", pad_o); end
  endtask

  initial begin
    test_reset();
    test_l16();
    test_l5();
    test_l0();
    test_l15();
    test_back_to_back_stall();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
